nibble_serial_adder: RTL and testbench



---
 rtl/nibble_add_pkg.sv | 6 +
 rtl/nibble_add4.sv | 12 +
 rtl/nibble_serial_adder.sv | 100 ++++++++++
 tb/tb_nibble_serial_adder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg: shared nibble width, nibble type and FSM state encoding for the serial adder
package nibble_add_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: combinational 4-bit add slice with carry in/out
module nibble_add4
  import nibble_add_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t s,
  output logic    cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder reusing one 4-bit slice per cycle, LS nibble first, valid/ready on both sides.
// Optional signed-overflow output ovf when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);
  if (WIDTH % NIBBLE_W != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout;
  nibble_t          w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_acc_n;
  nibble_add4 u_slice (
    .a    (r_a[NIBBLE_W-1:0]),
    .b    (r_b[NIBBLE_W-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );
  // the working accumulator is separate from r_sum so the previous result stays visible during ADD
  assign w_acc_n   = WIDTH'({w_s, r_acc} >> NIBBLE_W);
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign sum       = r_sum;
  assign cout      = r_cout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_cnt   <= '0;
        r_state <= ADD;
      end
    end else if (r_state == ADD) begin
      r_a     <= r_a >> NIBBLE_W;
      r_b     <= r_b >> NIBBLE_W;
      r_acc   <= w_acc_n;
      r_carry <= w_co;
      r_cnt   <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_sum   <= w_acc_n;
        r_cout  <= w_co;
        r_state <= DONE;
      end
    end else if (out_ready) begin
      r_state <= IDLE;
    end
  end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic r_am, r_bm, r_ovf;
  assign ovf = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_am  <= 1'b0;
      r_bm  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_am <= a[WIDTH-1];
      r_bm <= b[WIDTH-1];
    end else if (r_state == ADD && r_cnt == LAST) begin
      r_ovf <= (r_am == r_bm) && (w_s[NIBBLE_W-1] != r_am);
    end
  end
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of the serial adder against plain a+b+cin arithmetic
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif
  int errors = 0;
  int checks = 0;
  logic [15:0] prev_sum = '0;
  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input int stall);
    logic [16:0] e;
    int n;
    e = {1'b0, ta} + {1'b0, tb} + {16'b0, tc};
    out_ready = (stall == 0);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    check("in_ready_idle", {31'b0, in_ready}, 1);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 20) begin
      check("hold_prev_sum", {16'b0, sum}, {16'b0, prev_sum});
      check("busy_add", {31'b0, busy}, 1);
      in_valid = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check("latency", n, 4);
    check("sum", {16'b0, sum}, {16'b0, e[15:0]});
    check("cout", {31'b0, cout}, {31'b0, e[16]});
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("ovf", {31'b0, ovf}, {31'b0, (ta[15] == tb[15]) && (e[15] != ta[15])});
`endif
    repeat (stall) begin
      in_valid = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 1);
      check("stall_in_ready", {31'b0, in_ready}, 0);
      check("stall_sum", {16'b0, sum}, {16'b0, e[15:0]});
      check("stall_cout", {31'b0, cout}, {31'b0, e[16]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", {31'b0, out_valid}, 0);
    check("in_ready_back", {31'b0, in_ready}, 1);
    check("sum_held_idle", {16'b0, sum}, {16'b0, e[15:0]});
    check("cout_held_idle", {31'b0, cout}, {31'b0, e[16]});
    prev_sum = e[15:0];
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_sum", {16'b0, sum}, 0);
    check("rst_cout", {31'b0, cout}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    do_op(16'h1234, 16'h4321, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h000F, 16'h0000, 1'b1, 6);
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {31'b0, in_ready}, 1);
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_sum", {16'b0, sum}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_result", {31'b0, out_valid}, 0);
    end
    prev_sum = '0;
    do_op(16'h00FF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b1, 1);
    for (int i = 0; i < 25; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
